// File: rtl/fod_phase_ctrl.sv
// Fractional output divider phase controller: counts CLK periods and picks one of
// NPH multiphase clocks per output edge, with a sub-phase fraction accumulated on top.
module fod_phase_ctrl #(
    parameter int FW  = 12,
    parameter int NPH = 8
) (
    input  logic            CLK,
    input  logic            NRST,
    input  logic            EN,
    input  logic [7:0]      FCW_I,
    input  logic [2:0]      FCW_P,
    input  logic [FW-1:0]   FCW_F,
    output logic [2:0]      PHBIN,
    output logic [NPH-1:0]  PHSEL,
    output logic            FIRE,
    output logic            BUSY
);

    localparam int PW = $clog2(NPH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   tgt_q,  tgt_d;
    logic [FW-1:0]   facc_q, facc_d;
    logic [8:0]      cnt_q,  cnt_d;
    logic [PW-1:0]   phbin_d;
    logic [NPH-1:0]  phsel_d;
    logic            fire_d;
    logic            busy_d;

    // Step terms; LOAD computes from a zero phase/fraction origin.
    logic [PW-1:0]   base_tgt;
    logic [FW-1:0]   base_facc;
    logic [FW:0]     fsum;
    logic [PW:0]     psum;
    logic [7:0]      fi;
    logic [8:0]      cntl;

    always_comb begin
        base_tgt  = (state_q == ST_LOAD) ? '0 : tgt_q;
        base_facc = (state_q == ST_LOAD) ? '0 : facc_q;
        fsum      = {1'b0, base_facc} + {1'b0, FCW_F};
        psum      = {1'b0, base_tgt} + {1'b0, FCW_P} + {{PW{1'b0}}, fsum[FW]};
        fi        = (FCW_I < 8'd2) ? 8'd2 : FCW_I;
        cntl      = {1'b0, fi} + {8'd0, psum[PW]};
    end

    // State register
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = EN ? ST_LOAD : ST_IDLE;
            ST_LOAD: state_d = EN ? ST_RUN  : ST_IDLE;
            ST_RUN:  state_d = EN ? ST_RUN  : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; EN low always wins over a pending edge.
    always_comb begin
        tgt_d   = tgt_q;
        facc_d  = facc_q;
        cnt_d   = cnt_q;
        fire_d  = 1'b0;
        phbin_d = PHBIN;
        busy_d  = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                tgt_d  = '0;
                facc_d = '0;
                cnt_d  = '0;
            end
            ST_LOAD: begin
                if (EN) begin
                    tgt_d  = psum[PW-1:0];
                    facc_d = fsum[FW-1:0];
                    cnt_d  = cntl;
                end else begin
                    tgt_d  = '0;
                    facc_d = '0;
                    cnt_d  = '0;
                end
            end
            ST_RUN: begin
                if (!EN) begin
                    tgt_d  = '0;
                    facc_d = '0;
                    cnt_d  = '0;
                end else if (cnt_q <= 9'd1) begin
                    fire_d  = 1'b1;
                    phbin_d = tgt_q;
                    tgt_d   = psum[PW-1:0];
                    facc_d  = fsum[FW-1:0];
                    cnt_d   = cntl;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            default: begin
                tgt_d  = '0;
                facc_d = '0;
                cnt_d  = '0;
            end
        endcase
        phsel_d = NPH'(1) << phbin_d;
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            tgt_q  <= '0;
            facc_q <= '0;
            cnt_q  <= '0;
            PHBIN  <= '0;
            PHSEL  <= NPH'(1);
            FIRE   <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            tgt_q  <= tgt_d;
            facc_q <= facc_d;
            cnt_q  <= cnt_d;
            PHBIN  <= phbin_d;
            PHSEL  <= phsel_d;
            FIRE   <= fire_d;
            BUSY   <= busy_d;
        end
    end

    a_phsel_onehot: assert property (@(posedge CLK) disable iff (!NRST) $onehot(PHSEL));
    a_fire_busy:    assert property (@(posedge CLK) disable iff (!NRST) FIRE |-> BUSY);

endmodule

// File: doc/fod_phase_ctrl.md
FOD_PHASE_CTRL -- requirements
Module: fod_phase_ctrl

Interface
REQ-001 SHALL have parameter FW, default 12, giving the sub-phase fraction width.
REQ-002 SHALL have parameter NPH, default 8, giving the multiphase count; it is fixed at 8, so the phase pointer is 3 bits.
REQ-003 SHALL have port CLK, input, 1 bit: phase-0 clock of the 8-phase auxiliary PLL (FMP[0]); one clock only.
REQ-004 SHALL have port NRST, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port EN, input, 1 bit: run enable.
REQ-006 SHALL have port FCW_I, input, 8 bits: integer output period in CLK cycles.
REQ-007 SHALL have port FCW_P, input, 3 bits: phase step in units of 1/8 CLK period.
REQ-008 SHALL have port FCW_F, input, FW bits: sub-phase step in units of 1/2^FW phase.
REQ-009 SHALL have port PHBIN, output, 3 bits: binary phase index of the current output edge.
REQ-010 SHALL have port PHSEL, output, 8 bits: one-hot decode of PHBIN, selecting FMP[PHBIN].
REQ-011 SHALL have port FIRE, output, 1 bit: one-cycle strobe marking an output edge.
REQ-012 SHALL have port BUSY, output, 1 bit: high in LOAD and RUN.

Function
REQ-013 SHALL implement a state machine with states IDLE, LOAD and RUN; all outputs SHALL be registered on CLK rising edge.
REQ-014 SHALL hold 3-bit target phase TGT, FW-bit fraction accumulator FACC and 9-bit down-counter CNT.
REQ-015 SHALL use effective integer FI = max(FCW_I, 2), so FCW_I values 0 and 1 are clamped to 2.
REQ-016 SHALL form step terms from TGT, FACC and the current port values: {c, FACC'} = FACC + FCW_F (FW+1 bits); S = TGT + FCW_P + c (4 bits); TGT' = S[2:0]; wrap = S[3]; CNTL = FI + wrap (9 bits, max 256).
REQ-017 In IDLE, EN=1 at an edge SHALL move to LOAD; otherwise the block stays in IDLE with FIRE=0.
REQ-018 The LOAD edge SHALL set TGT, FACC and CNT from REQ-016, computed with TGT=0 and FACC=0, then move to RUN; LOAD lasts one cycle.
REQ-019 In RUN with CNT>1, each edge SHALL decrement CNT and drive FIRE=0.
REQ-020 In RUN with CNT==1, the edge SHALL set FIRE=1 and PHBIN=TGT, then load TGT', FACC' and CNTL per REQ-016.
REQ-021 SHALL space FIRE pulses exactly CNTL cycles apart, so the mean period is FI + (FCW_P + FCW_F/2^FW)/8 CLK cycles.
REQ-022 SHALL apply FCW changes at the next LOAD or CNT==1 edge only; mid-period changes SHALL have no effect on the current CNT.
REQ-023 EN=0 in LOAD or RUN SHALL move to IDLE at that edge, clearing TGT, FACC and CNT to 0 and forcing FIRE=0.
REQ-024 When EN=0 and a CNT==1 edge coincide, EN SHALL win: no FIRE is issued.
REQ-025 PHBIN and PHSEL SHALL hold their last value in IDLE.
REQ-026 PHSEL SHALL always equal 1<<PHBIN and SHALL never be zero or multi-hot.
REQ-027 Both TGT and FACC SHALL wrap modulo their width with no saturation.

Reset
REQ-028 NRST=0 SHALL immediately force state IDLE, with TGT=0, FACC=0, CNT=0, PHBIN=0, PHSEL=8'h01, FIRE=0 and BUSY=0.
REQ-029 Release of NRST SHALL be honoured at the next CLK edge.
REQ-030 Reset asserted mid-RUN SHALL abort the period with no FIRE.

Verification
REQ-031 FCW_I=4, FCW_P=0, FCW_F=0, EN rising -> LOAD for 1 cycle, then FIRE every 4 cycles with PHBIN=0 and PHSEL=8'h01.
REQ-032 FCW_I=4, FCW_P=3, FCW_F=0 -> successive PHBIN values 3, 6, 1, 4, 7, 2, 5, 0 and FIRE spacings 4, 4, 5, 4, 4, 5, 4, 5 cycles; the sum over 8 fires is 35 cycles.
REQ-033 FCW_I=5, FCW_P=0, FCW_F=2048 (FW=12) -> PHBIN alternates 0, 1, 1, 2, 2 … advancing every second fire; the mean period is 5.0625 cycles over 16 fires.
REQ-034 FCW_I=0 and FCW_I=1 -> both behave as FCW_I=2, giving FIRE every 2 cycles; FCW_I=255 with FCW_P=7 -> a spacing of 256 occurs without overflow.
REQ-035 EN dropped on the same edge as CNT==1 -> no FIRE, IDLE next cycle and PHBIN unchanged; re-enable restarts from TGT=0.
REQ-036 NRST pulsed low mid-RUN, asynchronously between edges -> outputs reach their reset values before the next edge; no FIRE until a fresh LOAD.
